dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_arbiter.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-core data-memory arbiter with round-robin grant and LR/SC reservations.
// One access is in flight at a time; a failing SC completes without touching memory.
module dmem_arbiter #(
    parameter int WORD_W   = 32,
    parameter int RESV_LSB = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [1:0]             dREN,
    input  logic [1:0]             dWEN,
    input  logic [1:0]             datomic,
    input  logic [1:0][WORD_W-1:0] daddr,
    input  logic [1:0][WORD_W-1:0] dstore,
    output logic [1:0]             dhit,
    output logic [1:0][WORD_W-1:0] dload,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [WORD_W-1:0]      ramaddr,
    output logic [WORD_W-1:0]      ramstore,
    input  logic [WORD_W-1:0]      ramload,
    input  logic                   ram_ready
);

    localparam int TAG_W = WORD_W - RESV_LSB;

    typedef enum logic {
        IDLE,
        SERVE
    } state_t;

    state_t                 state, state_next;
    logic                   g, g_next;
    logic                   p, p_next;
    logic [1:0]             resv_valid, resv_valid_next;
    logic [1:0][TAG_W-1:0]  resv_addr, resv_addr_next;

    logic [1:0]             req;
    logic [TAG_W-1:0]       cur_tag;
    logic                   is_write;
    logic                   is_read;
    logic                   is_lr;
    logic                   is_sc;
    logic                   sc_pass;
    logic                   sc_fail;
    logic                   done;

    assign req      = dREN | dWEN;
    assign cur_tag  = daddr[g][WORD_W-1:RESV_LSB];
    assign is_write = dWEN[g];
    assign is_read  = dREN[g] & ~dWEN[g];
    assign is_lr    = datomic[g] & is_read;
    assign is_sc    = datomic[g] & dWEN[g];
    assign sc_pass  = is_sc & resv_valid[g] & (resv_addr[g] == cur_tag);
    assign sc_fail  = is_sc & ~sc_pass;
    // A failing SC never waits on memory, so it finishes in the first SERVE cycle.
    assign done     = (state == SERVE) & (sc_fail | ram_ready);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            g          <= 1'b0;
            p          <= 1'b0;
            resv_valid <= '0;
            resv_addr  <= '0;
        end else begin
            state      <= state_next;
            g          <= g_next;
            p          <= p_next;
            resv_valid <= resv_valid_next;
            resv_addr  <= resv_addr_next;
        end
    end

    always_comb begin
        state_next      = state;
        g_next          = g;
        p_next          = p;
        resv_valid_next = resv_valid;
        resv_addr_next  = resv_addr;
        dhit            = '0;
        dload           = '0;
        ramREN          = 1'b0;
        ramWEN          = 1'b0;
        ramaddr         = '0;
        ramstore        = '0;

        case (state)
            IDLE: begin
                if (|req) begin
                    g_next     = (req == 2'b11) ? p : req[1];
                    state_next = SERVE;
                end
            end
            SERVE: begin
                ramaddr  = daddr[g];
                ramstore = dstore[g];
                ramREN   = is_read;
                ramWEN   = is_write & ~sc_fail;
                if (done) begin
                    dhit[g] = 1'b1;
                    if (sc_fail) begin
                        dload[g] = WORD_W'(1);
                    end else if (is_read) begin
                        dload[g] = ramload;
                    end
                    state_next = IDLE;
                    p_next     = ~g;
                    if (is_lr) begin
                        resv_valid_next[g] = 1'b1;
                        resv_addr_next[g]  = cur_tag;
                    end
                    // A committed store kills every reservation on the same word, the writer's included.
                    if (is_write & ~sc_fail) begin
                        for (int c = 0; c < 2; c++) begin
                            if (resv_addr[c] == cur_tag) begin
                                resv_valid_next[c] = 1'b0;
                            end
                        end
                    end
                    if (is_sc) begin
                        resv_valid_next[g] = 1'b0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter: arbitration, LR/SC, stalls and reset.
module tb_dmem_arbiter;

    logic             clk;
    logic             rst;
    logic [1:0]       dren;
    logic [1:0]       dwen;
    logic [1:0]       datomic;
    logic [1:0][31:0] daddr;
    logic [1:0][31:0] dstore;
    logic [1:0]       dhit;
    logic [1:0][31:0] dload;
    logic             ramren;
    logic             ramwen;
    logic [31:0]      ramaddr;
    logic [31:0]      ramstore;
    logic [31:0]      ramload;
    logic             ram_ready;

    int errors;
    int checks;

    dmem_arbiter #(.WORD_W(32), .RESV_LSB(2)) dut (
        .CLK(clk),
        .RST(rst),
        .dREN(dren),
        .dWEN(dwen),
        .datomic(datomic),
        .daddr(daddr),
        .dstore(dstore),
        .dhit(dhit),
        .dload(dload),
        .ramREN(ramren),
        .ramWEN(ramwen),
        .ramaddr(ramaddr),
        .ramstore(ramstore),
        .ramload(ramload),
        .ram_ready(ram_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request for core c, waits (bounded) for its completion and reports what was seen then.
    task automatic run_txn(input int c, input logic ren, input logic wen, input logic at,
                           input logic [31:0] addr, input logic [31:0] data,
                           output logic seen, output int lat, output logic [1:0] o_hit,
                           output logic [31:0] o_load, output logic o_wen,
                           output logic [31:0] o_addr, output logic [31:0] o_store);
        seen    = 1'b0;
        lat     = -1;
        o_hit   = 2'b00;
        o_load  = 32'hx;
        o_wen   = 1'bx;
        o_addr  = 32'hx;
        o_store = 32'hx;
        tick();
        dren[c]    = ren;
        dwen[c]    = wen;
        datomic[c] = at;
        daddr[c]   = addr;
        dstore[c]  = data;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dhit !== 2'b00) begin
                seen    = 1'b1;
                lat     = k;
                o_hit   = dhit;
                o_load  = dload[c];
                o_wen   = ramwen;
                o_addr  = ramaddr;
                o_store = ramstore;
                break;
            end
            tick();
        end
        tick();
        dren[c]    = 1'b0;
        dwen[c]    = 1'b0;
        datomic[c] = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        dren      = 2'b11;
        ram_ready = 1'b1;
        ramload   = 32'hFFFF_FFFF;
        daddr[0]  = 32'h1234;
        dstore[0] = 32'h5678;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if ({dhit, ramren, ramwen} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_strobes: got %b expected 0000", {dhit, ramren, ramwen});
        end
        checks++;
        if ({ramaddr, ramstore, dload} !== 128'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got addr=%h store=%h load=%h expected all 0",
                     ramaddr, ramstore, dload);
        end
        dren      = 2'b00;
        daddr[0]  = 32'h0;
        dstore[0] = 32'h0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        ram_ready = 1'b1;
        ramload   = 32'hDEAD_BEEF;
        tick();
        dren[0]  = 1'b1;
        daddr[0] = 32'h100;
        @(negedge clk);
        checks++;
        if ({ramren, dhit} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL read_idle_cycle: got ren/hit=%b expected 000", {ramren, dhit});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({ramren, ramwen, ramaddr} !== {2'b10, 32'h100}) begin
            errors++;
            $display("[TB] FAIL read_strobe: got ren=%b wen=%b addr=%h expected 1 0 100",
                     ramren, ramwen, ramaddr);
        end
        checks++;
        if (dhit !== 2'b01) begin
            errors++;
            $display("[TB] FAIL read_hit: got %b expected 01", dhit);
        end
        checks++;
        if (dload !== {32'h0, 32'hDEAD_BEEF}) begin
            errors++;
            $display("[TB] FAIL read_data: got %h expected 00000000deadbeef", dload);
        end
        tick();
        dren[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({dhit, ramren} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL read_after: got hit/ren=%b expected 000", {dhit, ramren});
        end
    endtask

    task automatic test_contention();
        int         order[$];
        int         exp_order[4];
        logic [1:0] pending;
        logic [1:0] h;
        exp_order = '{0, 1, 0, 1};
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        ram_ready = 1'b1;
        ramload   = 32'h0000_00AA;
        daddr[0]  = 32'h10;
        daddr[1]  = 32'h14;
        for (int r = 0; r < 2; r++) begin
            tick();
            dren    = 2'b11;
            pending = 2'b11;
            for (int cyc = 0; cyc < 12 && pending != 2'b00; cyc++) begin
                @(negedge clk);
                h = dhit;
                if (h[0]) order.push_back(0);
                if (h[1]) order.push_back(1);
                tick();
                dren    = dren & ~h;
                pending = pending & ~h;
            end
            checks++;
            if (pending !== 2'b00) begin
                errors++;
                $display("[TB] FAIL contention_timeout: round %0d pending=%b expected 00", r, pending);
            end
            dren = 2'b00;
        end
        checks++;
        if (order.size() != 4) begin
            errors++;
            $display("[TB] FAIL contention_count: got %0d grants expected 4", order.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (order[i] != exp_order[i]) begin
                    errors++;
                    $display("[TB] FAIL contention_order[%0d]: got core %0d expected core %0d",
                             i, order[i], exp_order[i]);
                end
            end
        end
    endtask

    task automatic test_lr_sc_pass();
        logic        seen;
        int          lat;
        logic [1:0]  h;
        logic [31:0] ld, ad, st;
        logic        we;
        ram_ready = 1'b1;
        ramload   = 32'h1234_5678;
        run_txn(1, 1'b1, 1'b0, 1'b1, 32'h200, 32'h0, seen, lat, h, ld, we, ad, st);
        checks++;
        if (!seen || h !== 2'b10 || lat != 1 || ld !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL lr1: got seen=%b hit=%b lat=%0d load=%h expected 1 10 1 12345678",
                     seen, h, lat, ld);
        end
        run_txn(1, 1'b0, 1'b1, 1'b1, 32'h200, 32'h55, seen, lat, h, ld, we, ad, st);
        checks++;
        if (!seen || h !== 2'b10 || we !== 1'b1 || st !== 32'h55 || ad !== 32'h200) begin
            errors++;
            $display("[TB] FAIL sc1_write: got seen=%b hit=%b wen=%b store=%h addr=%h expected 1 10 1 55 200",
                     seen, h, we, st, ad);
        end
        checks++;
        if (ld !== 32'h0) begin
            errors++;
            $display("[TB] FAIL sc1_result: got %h expected 0", ld);
        end
        run_txn(1, 1'b0, 1'b1, 1'b1, 32'h200, 32'h66, seen, lat, h, ld, we, ad, st);
        checks++;
        if (!seen || we !== 1'b0 || ld !== 32'h1) begin
            errors++;
            $display("[TB] FAIL sc_after_sc: got seen=%b wen=%b load=%h expected 1 0 1", seen, we, ld);
        end
    endtask

    task automatic test_lr_sc_break();
        logic        seen;
        int          lat;
        logic [1:0]  h;
        logic [31:0] ld, ad, st;
        logic        we;
        ram_ready = 1'b1;
        ramload   = 32'h0BAD_F00D;
        run_txn(0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h0, seen, lat, h, ld, we, ad, st);
        run_txn(1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h77, seen, lat, h, ld, we, ad, st);
        checks++;
        if (!seen || h !== 2'b10 || we !== 1'b1 || ld !== 32'h0) begin
            errors++;
            $display("[TB] FAIL plain_write: got seen=%b hit=%b wen=%b load=%h expected 1 10 1 0",
                     seen, h, we, ld);
        end
        ram_ready = 1'b0;
        run_txn(0, 1'b0, 1'b1, 1'b1, 32'h200, 32'h99, seen, lat, h, ld, we, ad, st);
        checks++;
        if (!seen || lat != 1 || h !== 2'b01) begin
            errors++;
            $display("[TB] FAIL sc_break_timing: got seen=%b lat=%0d hit=%b expected 1 1 01", seen, lat, h);
        end
        checks++;
        if (we !== 1'b0 || ld !== 32'h1) begin
            errors++;
            $display("[TB] FAIL sc_break_result: got wen=%b load=%h expected 0 1", we, ld);
        end
        ram_ready = 1'b1;
    endtask

    task automatic test_resv_granularity();
        logic        seen;
        int          lat;
        logic [1:0]  h;
        logic [31:0] ld, ad, st;
        logic        we;
        ram_ready = 1'b1;
        run_txn(0, 1'b1, 1'b0, 1'b1, 32'h300, 32'h0, seen, lat, h, ld, we, ad, st);
        run_txn(1, 1'b0, 1'b1, 1'b0, 32'h304, 32'h1, seen, lat, h, ld, we, ad, st);
        run_txn(0, 1'b0, 1'b1, 1'b1, 32'h302, 32'hAB, seen, lat, h, ld, we, ad, st);
        checks++;
        if (!seen || we !== 1'b1 || ld !== 32'h0 || ad !== 32'h302) begin
            errors++;
            $display("[TB] FAIL sc_same_word: got seen=%b wen=%b load=%h addr=%h expected 1 1 0 302",
                     seen, we, ld, ad);
        end
        run_txn(0, 1'b1, 1'b0, 1'b1, 32'h400, 32'h0, seen, lat, h, ld, we, ad, st);
        run_txn(0, 1'b0, 1'b1, 1'b1, 32'h404, 32'hCD, seen, lat, h, ld, we, ad, st);
        checks++;
        if (!seen || we !== 1'b0 || ld !== 32'h1) begin
            errors++;
            $display("[TB] FAIL sc_other_word: got seen=%b wen=%b load=%h expected 1 0 1", seen, we, ld);
        end
    endtask

    task automatic test_stall();
        int held;
        held      = 0;
        ram_ready = 1'b0;
        tick();
        dwen[0]   = 1'b1;
        daddr[0]  = 32'h40;
        dstore[0] = 32'hCAFE;
        tick();
        dren[1]  = 1'b1;
        daddr[1] = 32'h80;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ramwen === 1'b1 && ramaddr === 32'h40 && ramstore === 32'hCAFE && dhit === 2'b00) held++;
            tick();
        end
        ram_ready = 1'b1;
        ramload   = 32'hB0B0;
        @(negedge clk);
        checks++;
        if (held != 5) begin
            errors++;
            $display("[TB] FAIL stall_hold: got %0d held cycles expected 5", held);
        end
        checks++;
        if (dhit !== 2'b01 || ramwen !== 1'b1 || dload !== 64'h0) begin
            errors++;
            $display("[TB] FAIL stall_complete: got hit=%b wen=%b load=%h expected 01 1 0", dhit, ramwen, dload);
        end
        tick();
        dwen[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({dhit, ramren, ramwen} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL stall_gap: got %b expected 0000", {dhit, ramren, ramwen});
        end
        tick();
        @(negedge clk);
        checks++;
        if (dhit !== 2'b10 || ramren !== 1'b1 || ramaddr !== 32'h80 || dload[1] !== 32'hB0B0) begin
            errors++;
            $display("[TB] FAIL stall_waiter: got hit=%b ren=%b addr=%h load=%h expected 10 1 80 b0b0",
                     dhit, ramren, ramaddr, dload[1]);
        end
        tick();
        dren[1] = 1'b0;
    endtask

    task automatic test_reset_mid_serve();
        logic        seen;
        int          lat;
        logic [1:0]  h;
        logic [31:0] ld, ad, st;
        logic        we;
        ram_ready = 1'b1;
        ramload   = 32'h0;
        run_txn(0, 1'b1, 1'b0, 1'b1, 32'h500, 32'h0, seen, lat, h, ld, we, ad, st);
        ram_ready = 1'b0;
        tick();
        dren[1]  = 1'b1;
        daddr[1] = 32'h600;
        tick();
        @(negedge clk);
        checks++;
        if (ramren !== 1'b1 || ramaddr !== 32'h600) begin
            errors++;
            $display("[TB] FAIL mid_serve_setup: got ren=%b addr=%h expected 1 600", ramren, ramaddr);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({dhit, ramren, ramwen, ramaddr, ramstore, dload} !== 132'h0) begin
            errors++;
            $display("[TB] FAIL mid_serve_abort: got hit=%b ren=%b wen=%b addr=%h load=%h expected all 0",
                     dhit, ramren, ramwen, ramaddr, dload);
        end
        dren      = 2'b00;
        ram_ready = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (dhit !== 2'b00) begin
            errors++;
            $display("[TB] FAIL mid_serve_no_hit: got %b expected 00", dhit);
        end
        tick();
        rst      = 1'b0;
        ramload  = 32'h11;
        daddr[0] = 32'h700;
        dren     = 2'b11;
        tick();
        @(negedge clk);
        checks++;
        if (dhit !== 2'b01) begin
            errors++;
            $display("[TB] FAIL mid_serve_pointer: got %b expected 01", dhit);
        end
        tick();
        dren[0] = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (dhit !== 2'b10 || dload[1] !== 32'h11) begin
            errors++;
            $display("[TB] FAIL mid_serve_reissue: got hit=%b load=%h expected 10 11", dhit, dload[1]);
        end
        tick();
        dren[1] = 1'b0;
        run_txn(0, 1'b0, 1'b1, 1'b1, 32'h500, 32'hAA, seen, lat, h, ld, we, ad, st);
        checks++;
        if (!seen || we !== 1'b0 || ld !== 32'h1) begin
            errors++;
            $display("[TB] FAIL mid_serve_resv_cleared: got seen=%b wen=%b load=%h expected 1 0 1",
                     seen, we, ld);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        dren      = '0;
        dwen      = '0;
        datomic   = '0;
        daddr     = '0;
        dstore    = '0;
        ramload   = '0;
        ram_ready = 1'b0;
        test_reset();
        test_single_read();
        test_contention();
        test_lr_sc_pass();
        test_lr_sc_break();
        test_resv_granularity();
        test_stall();
        test_reset_mid_serve();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
